// File: rtl/noc_input_buffer.sv
// rtl/noc_input_buffer.sv - per-port first-word fall-through flit FIFO with credit return
// Optional INBUF_HWM_EN adds hwm_o, the high-water mark of the occupancy since reset.
module noc_input_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       valid_i,
    output logic                       credit_o,
    output logic [ADDR_W-1:0]          arb_address_o,
    output logic                       arb_empty_o,
    input  logic                       arb_read_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
`ifdef INBUF_HWM_EN
    output logic [$clog2(DEPTH):0]     hwm_o,
`endif
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              pop;
    logic              push;

    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign pop  = arb_read_i && (count != '0);
    assign push = valid_i && ((count < FULL_CNT) || pop);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_o   <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            credit_o <= pop;
            if (valid_i && !push) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef INBUF_HWM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_o <= '0;
        end else if (count_next > hwm_o) begin
            hwm_o <= count_next;
        end
    end
`endif

    assign arb_empty_o   = (count == '0);
    assign full_o        = (count == FULL_CNT);
    assign data_o        = arb_empty_o ? '0 : mem[rd_ptr];
    assign arb_address_o = data_o[ADDR_W-1:0];

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb/tb_noc_input_buffer.sv - randomized and directed bench for noc_input_buffer against a queue model
module tb_noc_input_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              credit_o;
    logic [ADDR_W-1:0] arb_address_o;
    logic              arb_empty_o;
    logic              arb_read_i;
    logic [DATA_W-1:0] data_o;
    logic              full_o;
    logic              overflow_o;
`ifdef INBUF_HWM_EN
    logic [$clog2(DEPTH):0] hwm_o;
`endif

    noc_input_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .credit_o      (credit_o),
        .arb_address_o (arb_address_o),
        .arb_empty_o   (arb_empty_o),
        .arb_read_i    (arb_read_i),
        .data_o        (data_o),
        .full_o        (full_o),
`ifdef INBUF_HWM_EN
        .hwm_o         (hwm_o),
`endif
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference state: the queue holds the flits in arrival order.
    logic [DATA_W-1:0] q[$];
    bit                m_credit;
    bit                m_ovf;
    int                m_hwm;
    int                credits_seen;
    int                pops_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [DATA_W-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        check("empty",    32'(arb_empty_o), 32'(q.size() == 0));
        check("full",     32'(full_o),      32'(q.size() == DEPTH));
        check("data",     data_o,           head);
        check("address",  32'(arb_address_o), 32'(head[ADDR_W-1:0]));
        check("credit",   32'(credit_o),    32'(m_credit));
        check("overflow", 32'(overflow_o),  32'(m_ovf));
`ifdef INBUF_HWM_EN
        check("hwm",      32'(hwm_o),       32'(m_hwm));
`endif
        if (credit_o === 1'b1) credits_seen++;
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [DATA_W-1:0] d, input bit rd);
        bit do_pop;
        bit do_push;
        if (r) begin
            q.delete();
            m_credit = 0;
            m_ovf    = 0;
            m_hwm    = 0;
            return;
        end
        do_pop  = rd && (q.size() != 0);
        do_push = v && (q.size() < DEPTH || do_pop);
        if (do_pop) begin
            void'(q.pop_front());
            pops_done++;
        end
        if (do_push) q.push_back(d);
        if (v && !do_push) m_ovf = 1;
        m_credit = do_pop;
        if (q.size() > m_hwm) m_hwm = q.size();
    endtask

    task automatic cycle(input bit r, input bit v, input logic [DATA_W-1:0] d, input bit rd);
        reset      = r;
        valid_i    = v;
        data_i     = d;
        arb_read_i = rd;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(r, v, d, rd);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        valid_i    = 1'b0;
        data_i     = '0;
        arb_read_i = 1'b0;
        credits_seen = 0;
        pops_done    = 0;
        @(posedge clk);
        model_edge(1, 0, '0, 0);
        #1;

        // Idle after reset
        repeat (3) cycle(0, 0, '0, 0);

        // Single flit, pop two cycles later, credit one cycle after pop
        cycle(0, 1, 32'h0000_0023, 0);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 0);

        // Fill to full, then pop on consecutive cycles
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h10 + i, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);
        repeat (2) cycle(0, 0, '0, 0);

        // Full with simultaneous push and pop: accepted, no overflow
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h10 + i, 0);
        cycle(0, 1, 32'h14, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);

        // Full with push and no pop: dropped, overflow sticks
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h20 + i, 0);
        cycle(0, 1, 32'h99, 0);
        repeat (2) cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);

        // Pointer wrap, then reset mid-traffic with three flits held
        cycle(1, 0, '0, 0);
        cycle(0, 1, 32'h31, 0);
        cycle(0, 1, 32'h32, 0);
        cycle(0, 1, 32'h33, 1);
        cycle(0, 1, 32'h34, 0);
        cycle(0, 1, 32'h35, 1);
        cycle(0, 0, '0, 0);
        check("count_before_reset", 32'(q.size()), 32'd3);
        cycle(1, 0, '0, 0);
        cycle(0, 1, 32'h36, 0);
        repeat (2) cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 9) < 6),
                  $urandom,
                  ($urandom_range(0, 1) == 1));
        end
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 0);

        check("credit_total", 32'(credits_seen), 32'(pops_done));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
